// File: rtl/tmr_cnt_ofuf_ctrl.sv
// Timer counter with prescaler and parallel load, plus per-flag of/uf clear handshake FSMs.
// Optional macro OFUF_AUTO_RELOAD_EN: on a counting wrap, cnt reloads from tdr instead.
module tmr_cnt_ofuf_ctrl #(
  parameter int CLR_PULSE = 2,
  parameter int CLR_RETRY = 3
) (
  input  logic       clk,
  input  logic       of_con_rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] tdr,
  input  logic [1:0] cks,
  input  logic       of_in,
  input  logic       uf_in,
  input  logic       clr_of,
  input  logic       clr_uf,
  output logic [7:0] cnt,
  output logic [1:0] rst_ofuf_n,
  output logic       irq_of,
  output logic       irq_uf,
  output logic [1:0] clr_busy,
  output logic [1:0] clr_err
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} clr_state_t;

  localparam logic [3:0] PULSE_LAST = 4'(CLR_PULSE - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(CLR_RETRY);

  logic [3:0] psc;
  logic [3:0] psc_top;
  logic       tick;
  logic [7:0] cnt_step;

  always_comb begin
    psc_top = 4'd1;
    case (cks)
      2'd0: psc_top = 4'd1;
      2'd1: psc_top = 4'd3;
      2'd2: psc_top = 4'd7;
      2'd3: psc_top = 4'd15;
      default: psc_top = 4'd1;
    endcase
  end

  assign tick = (psc == psc_top);

  always_comb begin
    cnt_step = up_dn ? cnt + 8'd1 : cnt - 8'd1;
`ifdef OFUF_AUTO_RELOAD_EN
    if ((up_dn && cnt == 8'hFF) || (!up_dn && cnt == 8'h00))
      cnt_step = tdr;
`endif
  end

  // Load restarts the prescaler so the first tick after a load is a full period away.
  always_ff @(posedge clk or negedge of_con_rst_n) begin
    if (!of_con_rst_n) begin
      psc <= 4'd0;
      cnt <= 8'h00;
    end else if (load) begin
      psc <= 4'd0;
      cnt <= tdr;
    end else begin
      psc <= tick ? 4'd0 : psc + 4'd1;
      if (tick && en)
        cnt <= cnt_step;
    end
  end

  logic [1:0] flag_meta;
  logic [1:0] flag_s;
  logic [1:0] flag_prev;
  logic [1:0] clr_req;
  logic [1:0] irq_vec;

  assign clr_req = {clr_uf, clr_of};

  always_ff @(posedge clk or negedge of_con_rst_n) begin
    if (!of_con_rst_n) begin
      flag_meta <= 2'b00;
      flag_s    <= 2'b00;
      flag_prev <= 2'b00;
    end else begin
      flag_meta <= {uf_in, of_in};
      flag_s    <= flag_meta;
      flag_prev <= flag_s;
    end
  end

  // Index 0 handles overflow, index 1 underflow.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_clr
      clr_state_t state;
      logic [3:0] timer;
      logic [2:0] attempts;
      logic       line;
      logic       busy;
      logic       err;
      logic       irq;

      always_ff @(posedge clk or negedge of_con_rst_n) begin
        if (!of_con_rst_n) begin
          state    <= IDLE;
          timer    <= 4'd0;
          attempts <= 3'd0;
          line     <= 1'b1;
          busy     <= 1'b0;
          err      <= 1'b0;
          irq      <= 1'b0;
        end else begin
          if (flag_s[gi] && !flag_prev[gi])
            irq <= 1'b1;
          else if (state == CHECK && !flag_s[gi])
            irq <= 1'b0;

          case (state)
            IDLE: begin
              if (clr_req[gi]) begin
                state    <= PULSE;
                line     <= 1'b0;
                busy     <= 1'b1;
                err      <= 1'b0;
                attempts <= 3'd1;
                timer    <= 4'd0;
              end
            end
            PULSE: begin
              if (timer == PULSE_LAST) begin
                state <= SETTLE;
                line  <= 1'b1;
                timer <= 4'd0;
              end else begin
                timer <= timer + 4'd1;
              end
            end
            SETTLE: begin
              // Three cycles let the detector's release propagate through the synchronizer.
              if (timer == 4'd2) begin
                state <= CHECK;
                timer <= 4'd0;
              end else begin
                timer <= timer + 4'd1;
              end
            end
            CHECK: begin
              if (!flag_s[gi]) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (attempts < RETRY_MAX) begin
                state    <= PULSE;
                line     <= 1'b0;
                attempts <= attempts + 3'd1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                err   <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end

      assign rst_ofuf_n[gi] = line;
      assign clr_busy[gi]   = busy;
      assign clr_err[gi]    = err;
      assign irq_vec[gi]    = irq;
    end
  endgenerate

  assign irq_of = irq_vec[0];
  assign irq_uf = irq_vec[1];

endmodule

// File: tb/tb_tmr_cnt_ofuf_ctrl.sv
// Directed bench for tmr_cnt_ofuf_ctrl: prescaler, wrap, clear handshake, stuck flag, concurrency, reset.
module tb_tmr_cnt_ofuf_ctrl;

  logic       clk = 1'b0;
  logic       of_con_rst_n;
  logic       en, up_dn, load;
  logic [7:0] tdr;
  logic [1:0] cks;
  logic       of_in, uf_in, clr_of, clr_uf;
  logic [7:0] cnt;
  logic [1:0] rst_ofuf_n;
  logic       irq_of, irq_uf;
  logic [1:0] clr_busy, clr_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tmr_cnt_ofuf_ctrl #(.CLR_PULSE(2), .CLR_RETRY(3)) dut (
    .clk(clk), .of_con_rst_n(of_con_rst_n), .en(en), .up_dn(up_dn), .load(load),
    .tdr(tdr), .cks(cks), .of_in(of_in), .uf_in(uf_in), .clr_of(clr_of), .clr_uf(clr_uf),
    .cnt(cnt), .rst_ofuf_n(rst_ofuf_n), .irq_of(irq_of), .irq_uf(irq_uf),
    .clr_busy(clr_busy), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int low_n, busy_n, pulses;
    logic prev_line;

    of_con_rst_n = 1'b0;
    en = 1'b0; up_dn = 1'b1; load = 1'b0; tdr = 8'h00; cks = 2'd0;
    of_in = 1'b0; uf_in = 1'b0; clr_of = 1'b0; clr_uf = 1'b0;

    // Reset state
    step(1);
    chk("rst_cnt", 32'(cnt), 32'h00);
    chk("rst_lines", 32'(rst_ofuf_n), 32'h3);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_err", 32'(clr_err), 32'h0);
    chk("rst_irq", 32'({irq_uf, irq_of}), 32'h0);

    // Prescaler: divide by 8
    of_con_rst_n = 1'b1; cks = 2'd2; en = 1'b1; up_dn = 1'b1;
    step(7);
    chk("psc_before_tick", 32'(cnt), 32'h00);
    step(1);
    chk("psc_first_tick", 32'(cnt), 32'h01);
    step(56);
    chk("psc_64_cycles", 32'(cnt), 32'h08);

    // Up wrap
    en = 1'b0; load = 1'b1; tdr = 8'hFE; cks = 2'd0;
    step(1);
    load = 1'b0; en = 1'b1; tdr = 8'h10;
    chk("load_fe", 32'(cnt), 32'hFE);
    step(2);
    chk("up_ff", 32'(cnt), 32'hFF);
    step(2);
`ifdef OFUF_AUTO_RELOAD_EN
    chk("up_wrap", 32'(cnt), 32'h10);
    step(2);
    chk("up_after_wrap", 32'(cnt), 32'h11);
`else
    chk("up_wrap", 32'(cnt), 32'h00);
    step(2);
    chk("up_after_wrap", 32'(cnt), 32'h01);
`endif

    // Down wrap
    en = 1'b0; load = 1'b1; tdr = 8'h01;
    step(1);
    load = 1'b0; en = 1'b1; up_dn = 1'b0; tdr = 8'h10;
    chk("load_01", 32'(cnt), 32'h01);
    step(2);
    chk("dn_00", 32'(cnt), 32'h00);
    step(2);
`ifdef OFUF_AUTO_RELOAD_EN
    chk("dn_wrap", 32'(cnt), 32'h10);
    step(2);
    chk("dn_after_wrap", 32'(cnt), 32'h0F);
`else
    chk("dn_wrap", 32'(cnt), 32'hFF);
    step(2);
    chk("dn_after_wrap", 32'(cnt), 32'hFE);
`endif
    en = 1'b0;

    // Overflow flag and successful clear
    of_in = 1'b1;
    step(2);
    chk("irq_of_latency2", 32'(irq_of), 32'h0);
    step(1);
    chk("irq_of_set", 32'(irq_of), 32'h1);
    clr_of = 1'b1;
    low_n = 0; busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (i == 0) begin
        clr_of = 1'b0;
        of_in = 1'b0;
      end
      if (!rst_ofuf_n[0]) low_n++;
      if (clr_busy[0]) busy_n++;
    end
    chk("of_low_cycles", 32'(low_n), 32'd2);
    chk("of_busy_cycles", 32'(busy_n), 32'd6);
    chk("of_irq_cleared", 32'(irq_of), 32'h0);
    chk("of_no_err", 32'(clr_err[0]), 32'h0);

    // Stuck underflow flag
    uf_in = 1'b1;
    step(3);
    chk("irq_uf_set", 32'(irq_uf), 32'h1);
    clr_uf = 1'b1;
    low_n = 0; busy_n = 0; pulses = 0; prev_line = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (i == 0) clr_uf = 1'b0;
      if (!rst_ofuf_n[1]) low_n++;
      if (prev_line && !rst_ofuf_n[1]) pulses++;
      if (clr_busy[1]) busy_n++;
      prev_line = rst_ofuf_n[1];
    end
    chk("uf_pulses", 32'(pulses), 32'd3);
    chk("uf_low_cycles", 32'(low_n), 32'd6);
    chk("uf_busy_cycles", 32'(busy_n), 32'd18);
    chk("uf_err", 32'(clr_err), 32'h2);
    chk("uf_irq_stays", 32'(irq_uf), 32'h1);
    chk("of_line_idle", 32'(rst_ofuf_n[0]), 32'h1);

    // Simultaneous clears with a load, flags already low
    uf_in = 1'b0;
    step(3);
    clr_of = 1'b1; clr_uf = 1'b1; load = 1'b1; tdr = 8'h5A;
    step(1);
    clr_of = 1'b0; clr_uf = 1'b0; load = 1'b0;
    chk("conc_lines", 32'(rst_ofuf_n), 32'h0);
    chk("conc_cnt", 32'(cnt), 32'h5A);
    chk("conc_busy", 32'(clr_busy), 32'h3);
    chk("conc_err_cleared", 32'(clr_err), 32'h0);
    step(6);
    chk("conc_done_busy", 32'(clr_busy), 32'h0);
    chk("conc_done_err", 32'(clr_err), 32'h0);
    chk("conc_irq_uf_cleared", 32'(irq_uf), 32'h0);

    // Asynchronous reset in the middle of a pulse
    clr_of = 1'b1;
    step(1);
    clr_of = 1'b0;
    chk("mid_pulse_low", 32'(rst_ofuf_n[0]), 32'h0);
    #2 of_con_rst_n = 1'b0;
    #1;
    chk("async_rst_lines", 32'(rst_ofuf_n), 32'h3);
    chk("async_rst_cnt", 32'(cnt), 32'h00);
    step(1);
    of_con_rst_n = 1'b1;
    step(1);
    chk("post_rst_busy", 32'(clr_busy), 32'h0);
    chk("post_rst_lines", 32'(rst_ofuf_n), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tmr_cnt_ofuf_ctrl.md
Name: tmr_cnt_ofuf_ctrl

Overview:
Counter-side controller for the 8-bit timer. It generates the cnt bus that the overflow/underflow detector monitors, using an up/down counter with a prescaler and a parallel load. It consumes the detector's of/uf flags and drives the rst_ofuf_n clear lines through a pulse-and-verify handshake. It also produces registered status and interrupt outputs for the register bank.

Parameters:
CLR_PULSE, 2, cycles rst_ofuf_n[n] is held low per clear attempt (1..15)
CLR_RETRY, 3, maximum pulse attempts before clr_err is set (1..7)

Ports:
clk  input  1  system clock, rising edge
of_con_rst_n  input  1  reset, asynchronous, active-low
en  input  1  count enable, level
up_dn  input  1  1 = count up, 0 = count down
load  input  1  single-cycle strobe: cnt <= tdr
tdr  input  8  load/reload value
cks  input  2  prescaler select: tick every 2^(cks+1) clk cycles (2, 4, 8, 16)
of_in  input  1  overflow flag from detector (asynchronous to clk)
uf_in  input  1  underflow flag from detector (asynchronous to clk)
clr_of  input  1  single-cycle software clear request for overflow
clr_uf  input  1  single-cycle software clear request for underflow
cnt  output  8  counter value (registered)
rst_ofuf_n  output  2  [1] = uf clear, [0] = of clear; active-low
irq_of  output  1  overflow interrupt, level
irq_uf  output  1  underflow interrupt, level
clr_busy  output  2  [1] = uf clear in progress, [0] = of clear in progress
clr_err  output  2  sticky error: flag still set after CLR_RETRY attempts

Behaviour:
- Reset values: cnt = 8'h00, prescaler = 0, rst_ofuf_n = 2'b11, irq_* = 0, clr_busy = 0, clr_err = 0, synchronizers = 0, both FSMs in IDLE.
- Prescaler: free-running 4-bit counter. tick = (psc == 2^(cks+1)-1); psc wraps to 0 on tick. A change to cks takes effect on the next compare; no glitch handling is required.
- Counter priority is load > tick&en > hold.
  - load: cnt <= tdr and psc <= 0 in the same cycle. A tick in that cycle is discarded.
  - tick&en, up_dn = 1: cnt <= cnt+1, wrapping 8'hFF -> 8'h00.
  - tick&en, up_dn = 0: cnt <= cnt-1, wrapping 8'h00 -> 8'hFF.
- Flag sync: of_in and uf_in each pass through a 2-flop synchronizer (of_s, uf_s). Latency from flag to synchronized value is 2 clk cycles.
- Interrupts: irq_of is set on an of_s rising edge (of_s = 1 and previous of_s = 0). It clears when the of clear FSM returns to IDLE with of_s = 0. If a set and a clear happen in the same cycle, set wins. irq_uf behaves identically for uf.
- Clear FSM, one independent instance per flag (shown for n = of):
  - IDLE: rst_ofuf_n[n] = 1, clr_busy[n] = 0. On clr_of, go to PULSE, attempts <= 1, clear clr_err[n]. A clr_of while not in IDLE is ignored.
  - PULSE: rst_ofuf_n[n] = 0 for exactly CLR_PULSE cycles, then go to SETTLE.
  - SETTLE: rst_ofuf_n[n] = 1 for 3 cycles to cover synchronizer latency, then go to CHECK.
  - CHECK (1 cycle):
    - of_s = 0 -> IDLE.
    - else if attempts < CLR_RETRY -> PULSE, attempts+1.
    - else set clr_err[n] and go to IDLE.
  - clr_busy[n] = 1 in every state except IDLE.
- The of and uf FSMs may run simultaneously; both lines may be low in the same cycle.
- A clear request with the flag already 0 still runs one full PULSE/SETTLE/CHECK sequence and returns to IDLE with no error.
- Reset mid-operation: an asynchronous reset drives rst_ofuf_n high immediately and aborts both FSMs to IDLE.

Optional Feature:
OFUF_AUTO_RELOAD_EN:
- Defined: on a counting tick where cnt would wrap (8'hFF up, or 8'h00 down), cnt <= tdr instead of the wrap value. load behaviour is unchanged.
- Undefined: plain modular wrap as described in Behaviour, and no reload logic is synthesized.

Test Plan:
1. Reset: assert of_con_rst_n low mid-PULSE -> cnt = 00 and rst_ofuf_n = 11 in the same cycle; after release, clr_busy = 00.
2. Prescaler: cks = 2, en = 1, up_dn = 1 from cnt = 00 -> cnt increments every 8 clk cycles; after 64 cycles cnt = 08.
3. Wrap: load tdr = FE, count up 3 ticks -> FF, 00, 01. Load 01, count down 3 ticks -> 00, FF, FE. With OFUF_AUTO_RELOAD_EN and tdr = 10, the up wrap after FF gives 10.
4. Clear handshake: of_in = 1 -> irq_of = 1 after 3 cycles. clr_of pulse with of_in dropping when rst_ofuf_n[0] goes low -> rst_ofuf_n[0] low for 2 cycles, clr_busy[0] high for 6 cycles, then irq_of = 0 and clr_err[0] = 0.
5. Stuck flag: hold uf_in = 1 and pulse clr_uf -> 3 low pulses of 2 cycles each on rst_ofuf_n[1], clr_err[1] = 1, irq_uf stays 1.
6. Concurrency: clr_of and clr_uf in the same cycle, with load asserted in that cycle -> both rst_ofuf_n bits low together, and cnt = tdr on the next edge.
